pipeline_stage_reg: RTL and testbench
=====================================

Name: pipeline_stage_reg

Overview:
- Generic, parametrised pipeline register for any inter-stage boundary (IF/ID, ID/EX, EX/MEMEX, MEMEX/WB).
- Carries an opaque payload plus a side-effect field (register-file WE, memory WE, and similar).
- Side-effect bits are forced to zero for entries marked invalid.
- Adds a valid/ready handshake, an optional 2-entry skid buffer, synchronous flush, and a saturating stall counter, so all stage registers share one verified block.

Parameters:
- DATA_W, 32, payload width in bits (pc4, rd, alu_result, immediate, etc. packed by the instantiating stage).
- SE_W, 1, side-effect field width; every bit is cleared when the entry is invalid.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- STALL_CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset: one clock; reset is synchronous and active-low.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream has an entry.
- in_invalid  in  1  entry is a bubble or poisoned (e.g. squashed by a branch).
- in_data  in  DATA_W  payload.
- in_se  in  SE_W  side-effect enables.
- in_ready  out  1  block can accept this cycle.
- out_valid  out  1  head entry present.
- out_invalid  out  1  head entry is invalid.
- out_data  out  DATA_W  head payload.
- out_se  out  SE_W  head side-effects, always 0 when out_invalid = 1.
- out_ready  in  1  downstream accepts the head.
- stall_cycles  out  STALL_CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Handshakes:
  - Accept = in_valid & in_ready.
  - Retire = out_valid & out_ready.
  - FIFO ordering; no entry is dropped or duplicated.
- Reset (rst_n=0 at posedge):
  - state EMPTY; out_valid=0, out_invalid=0, out_data=0, out_se=0, stall_cycles=0.
  - Inputs are ignored.
  - in_ready=1 once in EMPTY.
- Write rule: the stored se = in_invalid ? 0 : in_se. The stored invalid flag = in_invalid. Data is stored unchanged.
- SKID=1 state machine (head register H, skid register S):
  - EMPTY: accept -> ONE (H loaded).
  - ONE:
    - accept & retire -> ONE (H reloaded).
    - accept & !retire -> TWO (S loaded).
    - retire & !accept -> EMPTY.
  - TWO: in_ready=0.
    - retire -> ONE (H<=S).
    - Otherwise hold.
  - in_ready = (state != TWO). It depends only on registered state; there is no combinational out_ready->in_ready path.
- SKID=0:
  - Single register H.
  - in_ready = !out_valid | out_ready (combinational).
  - Accept loads H.
  - Retire without accept clears out_valid.
- Latency: 1 cycle from accept into EMPTY to out_valid=1. Throughput is 1 entry/cycle when out_ready is held high.
- flush=1 at posedge:
  - All entries are discarded; state EMPTY; out_valid=0, out_invalid=0, out_se=0.
  - An accept in the same cycle is discarded. Upstream sees a handshake, and the entry is dropped intentionally.
  - Priority: reset > flush > accept/retire.
  - out_data may hold stale data while out_valid=0.
- stall_cycles:
  - Increments on each posedge with out_valid & !out_ready.
  - Saturates at all-ones; there is no wrap.
  - Cleared only by reset, not by flush.
- Simultaneous accept and retire in TWO is impossible because in_ready=0.
- When out_valid=0, out_invalid and out_se are 0.

Test Plan:
1. Reset, then one accept with data=0x0000_1004, se=1, invalid=0; out_ready=1. Required: out_valid=1 the next cycle, out_data=0x0000_1004, out_se=1; out_valid=0 one cycle later.
2. Poison: accept with in_invalid=1, in_se=1, data=0xDEAD_BEEF. Required: out_invalid=1, out_se=0, out_data=0xDEAD_BEEF.
3. Backpressure (SKID=1): push 0xA, 0xB, 0xC on consecutive cycles with out_ready=0. Required:
   - 0xA and 0xB are accepted; in_ready=0 on the third cycle, so 0xC is held upstream.
   - Raise out_ready: outputs appear in order 0xA, 0xB, 0xC.
   - stall_cycles equals the number of stalled cycles.
4. Flush in state TWO with a concurrent in_valid. Required: the next cycle has out_valid=0 and in_ready=1; no entry appears afterwards; stall_cycles is unchanged.
5. Saturation with STALL_CNT_W=4: hold out_valid=1 and out_ready=0 for 20 cycles. Required: stall_cycles=15 and stays at 15.
6. Reset mid-operation with rst_n=0 in state TWO. Required: all outputs are zero at the next posedge; in_ready=1; the pre-reset entries never appear.

Source files
------------

// File: rtl/pipeline_stage_reg_if.sv
// Handshake bundle for one pipeline stage register: upstream entry, downstream head, flush and stall count.
// slave = the stage register itself, master = the surrounding pipeline logic.
interface pipeline_stage_reg_if #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SE_W        = 1,
  parameter int unsigned STALL_CNT_W = 16
) ();
  logic                   flush;
  logic                   in_valid;
  logic                   in_invalid;
  logic [DATA_W-1:0]      in_data;
  logic [SE_W-1:0]        in_se;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_invalid;
  logic [DATA_W-1:0]      out_data;
  logic [SE_W-1:0]        out_se;
  logic                   out_ready;
  logic [STALL_CNT_W-1:0] stall_cycles;

  modport slave (
    input  flush, in_valid, in_invalid, in_data, in_se, out_ready,
    output in_ready, out_valid, out_invalid, out_data, out_se, stall_cycles
  );

  modport master (
    output flush, in_valid, in_invalid, in_data, in_se, out_ready,
    input  in_ready, out_valid, out_invalid, out_data, out_se, stall_cycles
  );
endinterface

// File: rtl/pipeline_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready, optional 2-entry skid,
// synchronous flush, side-effect masking for invalid entries and a saturating stall counter.
module pipeline_stage_reg #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SE_W        = 1,
  parameter int unsigned SKID        = 1,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_stage_reg_if.slave  bus
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state_q, state_d;

  logic                   accept, retire, ready_w, valid_w;
  logic                   load_h_in, load_h_s, load_s, clr_h;
  logic [SE_W-1:0]        in_se_masked;
  logic [DATA_W-1:0]      h_data, s_data;
  logic                   h_inv, s_inv;
  logic [SE_W-1:0]        h_se, s_se;
  logic [STALL_CNT_W-1:0] stall_q;

  // Without the skid entry, ready must look through to out_ready to keep full throughput.
  generate
    if (SKID != 0) begin : g_skid
      assign ready_w = (state_q != TWO);
    end else begin : g_noskid
      assign ready_w = (state_q == EMPTY) || bus.out_ready;
    end
  endgenerate

  assign valid_w      = (state_q != EMPTY);
  assign accept       = bus.in_valid & ready_w;
  assign retire       = valid_w & bus.out_ready;
  assign in_se_masked = bus.in_invalid ? '0 : bus.in_se;

  assign bus.in_ready     = ready_w;
  assign bus.out_valid    = valid_w;
  assign bus.out_invalid  = h_inv;
  assign bus.out_data     = h_data;
  assign bus.out_se       = h_se;
  assign bus.stall_cycles = stall_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n)         state_q <= EMPTY;
    else if (bus.flush) state_q <= EMPTY;
    else                state_q <= state_d;
  end

  // Next state and datapath load controls; TWO is unreachable when SKID=0
  always_comb begin
    state_d   = state_q;
    load_h_in = 1'b0;
    load_h_s  = 1'b0;
    load_s    = 1'b0;
    clr_h     = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d   = ONE;
          load_h_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && retire) begin
          load_h_in = 1'b1;
        end else if (accept) begin
          state_d = TWO;
          load_s  = 1'b1;
        end else if (retire) begin
          state_d = EMPTY;
          clr_h   = 1'b1;
        end
      end
      TWO: begin
        if (retire) begin
          state_d  = ONE;
          load_h_s = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Head/skid storage; flags are cleared whenever the head empties so idle outputs read zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_data <= '0;
      h_inv  <= 1'b0;
      h_se   <= '0;
      s_data <= '0;
      s_inv  <= 1'b0;
      s_se   <= '0;
    end else if (bus.flush) begin
      h_inv <= 1'b0;
      h_se  <= '0;
      s_inv <= 1'b0;
      s_se  <= '0;
    end else begin
      if (load_h_in) begin
        h_data <= bus.in_data;
        h_inv  <= bus.in_invalid;
        h_se   <= in_se_masked;
      end else if (load_h_s) begin
        h_data <= s_data;
        h_inv  <= s_inv;
        h_se   <= s_se;
      end else if (clr_h) begin
        h_inv <= 1'b0;
        h_se  <= '0;
      end
      if (load_s) begin
        s_data <= bus.in_data;
        s_inv  <= bus.in_invalid;
        s_se   <= in_se_masked;
      end
    end
  end

  // Stall counter survives flush; only reset clears it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (valid_w && !bus.out_ready && (stall_q != {STALL_CNT_W{1'b1}})) begin
      stall_q <= stall_q + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Scoreboard bench for pipeline_stage_reg: SKID=1 instance tracked by a queue model,
// SKID=0 instance with a 4-bit stall counter exercised directly.
module tb_pipeline_stage_reg;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipeline_stage_reg_if #(.DATA_W(32), .SE_W(1), .STALL_CNT_W(16)) bus  ();
  pipeline_stage_reg_if #(.DATA_W(32), .SE_W(1), .STALL_CNT_W(4))  bus0 ();

  pipeline_stage_reg #(.DATA_W(32), .SE_W(1), .SKID(1), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  pipeline_stage_reg #(.DATA_W(32), .SE_W(1), .SKID(0), .STALL_CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));

  typedef struct packed {
    logic [31:0] data;
    logic        inv;
    logic        se;
  } exp_t;

  exp_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   stall_m    = 0;
  bit   mon_en     = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor for the SKID=1 instance; predicts the coming edge from mid-cycle inputs
  always @(negedge clk) begin : mon
    bit   mvalid, mready, acc, ret;
    exp_t e;
    if (mon_en) begin
      mvalid = (sb.size() != 0);
      mready = (sb.size() < 2);
      vectors++;
      if (bus.out_valid !== mvalid) begin
        miscompares++;
        $display("FAIL out_valid: got %b want %b at %0t", bus.out_valid, mvalid, $time);
      end
      vectors++;
      if (bus.in_ready !== mready) begin
        miscompares++;
        $display("FAIL in_ready: got %b want %b at %0t", bus.in_ready, mready, $time);
      end
      vectors++;
      if (bus.stall_cycles !== 16'(stall_m)) begin
        miscompares++;
        $display("FAIL stall_cycles: got %0d want %0d at %0t", bus.stall_cycles, stall_m, $time);
      end
      if (!mvalid) begin
        vectors++;
        if (bus.out_invalid !== 1'b0 || bus.out_se !== 1'b0) begin
          miscompares++;
          $display("FAIL idle_flags: got inv=%b se=%b want 0/0 at %0t", bus.out_invalid, bus.out_se, $time);
        end
      end
      ret = mvalid && bus.out_ready;
      acc = bus.in_valid && mready;
      if (ret) begin
        e = sb[0];
        vectors++;
        if (bus.out_data !== e.data || bus.out_invalid !== e.inv || bus.out_se !== e.se) begin
          miscompares++;
          $display("FAIL retire_head: got %h/%b/%b want %h/%b/%b at %0t",
                   bus.out_data, bus.out_invalid, bus.out_se, e.data, e.inv, e.se, $time);
        end
      end
      if (!rst_n) begin
        sb.delete();
        stall_m = 0;
      end else begin
        if (mvalid && !bus.out_ready && stall_m != 65535) stall_m++;
        if (bus.flush) begin
          sb.delete();
        end else begin
          if (ret) void'(sb.pop_front());
          if (acc) sb.push_back({bus.in_data, bus.in_invalid, bus.in_invalid ? 1'b0 : bus.in_se});
        end
      end
    end
  end

  task automatic test_reset();
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0000_0055;
    bus.in_se    = 1'b1;
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_invalid !== 1'b0 || bus.out_data !== 32'h0 ||
        bus.out_se !== 1'b0 || bus.stall_cycles !== 16'h0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b i=%b d=%h se=%b st=%0d rdy=%b want 0/0/0/0/0/1",
               bus.out_valid, bus.out_invalid, bus.out_data, bus.out_se, bus.stall_cycles, bus.in_ready);
    end
    vectors++;
    if (bus0.out_valid !== 1'b0 || bus0.stall_cycles !== 4'h0 || bus0.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state0: got v=%b st=%0d rdy=%b want 0/0/1",
               bus0.out_valid, bus0.stall_cycles, bus0.in_ready);
    end
    bus.in_valid = 1'b0;
    bus.in_se    = 1'b0;
    rst_n        = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bus.out_ready  = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_invalid = 1'b0;
    bus.in_data    = 32'h0000_1004;
    bus.in_se      = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0000_1004 || bus.out_se !== 1'b1) begin
      miscompares++;
      $display("FAIL single_out: got v=%b d=%h se=%b want 1/00001004/1", bus.out_valid, bus.out_data, bus.out_se);
    end
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_drain: got out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_poison();
    bus.out_ready  = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_invalid = 1'b1;
    bus.in_se      = 1'b1;
    bus.in_data    = 32'hDEAD_BEEF;
    tick();
    bus.in_valid   = 1'b0;
    bus.in_invalid = 1'b0;
    vectors++;
    if (bus.out_invalid !== 1'b1 || bus.out_se !== 1'b0 || bus.out_data !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL poison: got i=%b se=%b d=%h want 1/0/deadbeef", bus.out_invalid, bus.out_se, bus.out_data);
    end
    bus.out_ready = 1'b1;
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_invalid !== 1'b0) begin
      miscompares++;
      $display("FAIL poison_drain: got v=%b i=%b want 0/0", bus.out_valid, bus.out_invalid);
    end
  endtask

  task automatic test_backpressure();
    int s0;
    s0 = stall_m;
    bus.out_ready = 1'b0;
    bus.in_se     = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hA;
    tick();
    bus.in_data = 32'hB;
    tick();
    bus.in_data = 32'hC;
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_full: got in_ready=%b want 0", bus.in_ready);
    end
    tick();
    vectors++;
    if (bus.out_data !== 32'hA || bus.stall_cycles !== 16'(s0 + 2)) begin
      miscompares++;
      $display("FAIL bp_hold: got d=%h st=%0d want a/%0d", bus.out_data, bus.stall_cycles, s0 + 2);
    end
    bus.out_ready = 1'b1;
    tick();
    vectors++;
    if (bus.out_data !== 32'hB || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_second: got d=%h rdy=%b want b/1", bus.out_data, bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_data !== 32'hC) begin
      miscompares++;
      $display("FAIL bp_third: got d=%h want c", bus.out_data);
    end
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.stall_cycles !== 16'(s0 + 2)) begin
      miscompares++;
      $display("FAIL bp_end: got v=%b st=%0d want 0/%0d", bus.out_valid, bus.stall_cycles, s0 + 2);
    end
  endtask

  task automatic test_flush();
    int sb4;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h11;
    tick();
    bus.in_data = 32'h22;
    tick();
    sb4           = stall_m;
    bus.in_data   = 32'h33;
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.stall_cycles !== 16'(sb4)) begin
      miscompares++;
      $display("FAIL flush_two: got v=%b rdy=%b st=%0d want 0/1/%0d", bus.out_valid, bus.in_ready, bus.stall_cycles, sb4);
    end
    repeat (3) tick();
    // Accept in the same cycle as a flush is swallowed
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h44;
    tick();
    bus.in_data = 32'h55;
    bus.flush   = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_accept: got out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_data = $urandom;
      bus.in_se   = 1'($urandom_range(0, 1));
      tick();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_%0d: got v=%b rdy=%b want 1/1", i, bus.out_valid, bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      bus.in_valid   = 1'($urandom_range(0, 1));
      bus.in_invalid = ($urandom_range(0, 3) == 0);
      bus.in_se      = 1'($urandom_range(0, 1));
      bus.in_data    = $urandom;
      bus.out_ready  = ($urandom_range(0, 2) != 0);
      bus.flush      = ($urandom_range(0, 40) == 0);
      tick();
    end
    bus.in_valid   = 1'b0;
    bus.in_invalid = 1'b0;
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b1;
    repeat (3) tick();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL random_drain: got out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_se     = 1'b1;
    bus.in_data   = 32'h66;
    tick();
    bus.in_data = 32'h77;
    tick();
    bus.in_data = 32'h88;
    rst_n       = 1'b0;
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_invalid !== 1'b0 || bus.out_data !== 32'h0 ||
        bus.out_se !== 1'b0 || bus.stall_cycles !== 16'h0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid: got v=%b i=%b d=%h se=%b st=%0d rdy=%b want 0/0/0/0/0/1",
               bus.out_valid, bus.out_invalid, bus.out_data, bus.out_se, bus.stall_cycles, bus.in_ready);
    end
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_ghost: got out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_skid0_saturation();
    bus0.out_ready = 1'b0;
    bus0.in_valid  = 1'b1;
    bus0.in_data   = 32'h99;
    tick();
    bus0.in_valid = 1'b0;
    vectors++;
    if (bus0.out_valid !== 1'b1 || bus0.out_data !== 32'h99 || bus0.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL skid0_hold: got v=%b d=%h rdy=%b want 1/99/0", bus0.out_valid, bus0.out_data, bus0.in_ready);
    end
    bus0.out_ready = 1'b1;
    #1;
    vectors++;
    if (bus0.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL skid0_comb_ready: got in_ready=%b want 1", bus0.in_ready);
    end
    bus0.out_ready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      vectors++;
      if (bus0.stall_cycles !== 4'((i > 15) ? 15 : i)) begin
        miscompares++;
        $display("FAIL stall_sat_%0d: got %0d want %0d", i, bus0.stall_cycles, (i > 15) ? 15 : i);
      end
    end
    // Simultaneous accept and retire reloads the single entry
    bus0.out_ready = 1'b1;
    bus0.in_valid  = 1'b1;
    bus0.in_data   = 32'hAB;
    tick();
    bus0.in_valid = 1'b0;
    vectors++;
    if (bus0.out_valid !== 1'b1 || bus0.out_data !== 32'hAB || bus0.stall_cycles !== 4'd15) begin
      miscompares++;
      $display("FAIL skid0_reload: got v=%b d=%h st=%0d want 1/ab/15", bus0.out_valid, bus0.out_data, bus0.stall_cycles);
    end
    tick();
    vectors++;
    if (bus0.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL skid0_drain: got out_valid=%b want 0", bus0.out_valid);
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.flush       = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_invalid  = 1'b0;
    bus.in_data     = '0;
    bus.in_se       = 1'b0;
    bus.out_ready   = 1'b0;
    bus0.flush      = 1'b0;
    bus0.in_valid   = 1'b0;
    bus0.in_invalid = 1'b0;
    bus0.in_data    = '0;
    bus0.in_se      = 1'b0;
    bus0.out_ready  = 1'b0;
    tick();
    mon_en = 1'b1;
    test_reset();
    test_single();
    test_poison();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_skid0_saturation();
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
